data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 34 +++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
// Holds the FSM state type, word/byte-enable widths and the wait-state limit.
package dmem_pkg;

    localparam int WORD_W   = 32;
    localparam int BE_W     = WORD_W / 8;
    localparam int MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage with one byte-lane-masked write port and one async read port.
// Ports: clk, we/waddr/be/wdata (write), raddr -> rdata (read, pre-write data).
import dmem_pkg::*;

module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BE_W-1:0]   be,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // No reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Async read sees the word before the edge that writes it.
    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data-memory responder: req/gnt accept, one-cycle rvalid reply.
// Ports: clk, rst (async, active-low), req_i/we_i/addr_i/wdata_i/be_i in,
// gnt_o/rvalid_o/rdata_o/err_o out. Macro DMEM_ALIGN_CHECK_EN flags
// misaligned addresses as errors; undefined, addr[1:0] is ignored.
import dmem_pkg::*;

module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t          state;
    logic [3:0]      cnt;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;

    logic            idle;
    logic            acc_we;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_be;
    logic            acc_err;
    logic            enter_resp;
    logic            mem_we;
    logic            resp_err;
    logic [31:0]     mem_rdata;

    function automatic logic addr_bad(input logic [31:0] a);
        logic bad;
        // Compared in 33 bits so the limit never wraps.
        bad = ({1'b0, a} >= LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
        bad = bad | (a[1:0] != 2'b00);
`endif
        return bad;
    endfunction

    assign idle  = (state == IDLE);
    assign gnt_o = rst & idle & req_i;

    // With zero wait states the write commits on the accepting edge,
    // before the capture registers hold the request.
    assign acc_we    = idle ? we_i    : we_q;
    assign acc_addr  = idle ? addr_i  : addr_q;
    assign acc_wdata = idle ? wdata_i : wdata_q;
    assign acc_be    = idle ? be_i    : be_q;
    assign acc_err   = addr_bad(acc_addr);

    assign enter_resp = rst & (
        (gnt_o & (WAIT_CYCLES == 0)) |
        ((state == WAIT) & (cnt == 4'd0)));

    assign mem_we = enter_resp & acc_we & ~acc_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_o) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (acc_addr[AW+1:2]),
        .be    (acc_be),
        .wdata (acc_wdata),
        .raddr (addr_q[AW+1:2]),
        .rdata (mem_rdata)
    );

    assign resp_err = addr_bad(addr_q);
    assign rvalid_o = (state == RESP);
    assign err_o    = rvalid_o & resp_err;
    assign rdata_o  = (rvalid_o & ~resp_err) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array model.
// Two instances: WAIT_CYCLES=1 (index 0) and WAIT_CYCLES=0 (index 1).
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata [2];
    logic [1:0]  err;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: only words 0..15 are ever addressed in range.
    logic [31:0] mem_m [2][16];

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req[0]),
        .we_i     (we[0]),
        .addr_i   (addr[0]),
        .wdata_i  (wdata[0]),
        .be_i     (be[0]),
        .gnt_o    (gnt[0]),
        .rvalid_o (rvalid[0]),
        .rdata_o  (rdata[0]),
        .err_o    (err[0])
    );

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (0)
    ) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req[1]),
        .we_i     (we[1]),
        .addr_i   (addr[1]),
        .wdata_i  (wdata[1]),
        .be_i     (be[1]),
        .gnt_o    (gnt[1]),
        .rvalid_o (rvalid[1]),
        .rdata_o  (rdata[1]),
        .err_o    (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
        logic e;
        e = (a >= 32'h1000);
`ifdef DMEM_ALIGN_CHECK_EN
        e = e || (a[1:0] != 2'b00);
`endif
        return e;
    endfunction

    task automatic do_access(input int d, input logic w,
                             input logic [31:0] a,
                             input logic [31:0] wd,
                             input logic [3:0] b,
                             output logic [31:0] rd,
                             output logic e);
        logic        exp_e;
        logic [31:0] exp_rd;
        int          lat;
        exp_e  = model_err(a);
        exp_rd = 32'd0;
        if (!w && !exp_e) exp_rd = mem_m[d][a[5:2]];
        @(negedge clk);
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        be[d]    = b;
        #1;
        chk("gnt", 32'(gnt[d]), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs: the captured request must be used.
        req[d]   = 1'b0;
        we[d]    = 1'($urandom);
        addr[d]  = $urandom;
        wdata[d] = $urandom;
        be[d]    = 4'($urandom);
        lat = 0;
        rd  = 32'd0;
        e   = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rvalid[d]) break;
        end
        chk("latency", 32'(lat), (d == 0) ? 32'd2 : 32'd1);
        rd = rdata[d];
        e  = err[d];
        chk("err", 32'(err[d]), 32'(exp_e));
        if (!w || exp_e) chk("rdata", rdata[d], exp_rd);
        if (w && !exp_e) begin
            for (int n = 0; n < 4; n++) begin
                if (b[n]) mem_m[d][a[5:2]][8*n +: 8] = wd[8*n +: 8];
            end
        end
        @(negedge clk);
        chk("rvalid_one_cycle", 32'(rvalid[d]), 32'd0);
        chk("rdata_idle", rdata[d], 32'd0);
    endtask

    logic [31:0] rd;
    logic        e;
    logic [31:0] exp36;

    initial begin
        rst = 1'b0;
        req = 2'b11;
        for (int d = 0; d < 2; d++) begin
            we[d]    = 1'b1;
            addr[d]  = 32'h10;
            wdata[d] = 32'hFFFF_FFFF;
            be[d]    = 4'hF;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_gnt", 32'(gnt[d]), 32'd0);
            chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
        end
        @(negedge clk);
        req = 2'b00;
        rst = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                do_access(d, 1'b1, 32'(w * 4), $urandom, 4'hF, rd, e);
            end
        end

        do_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, e);
        do_access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e);
        chk("ld_deadbeef", rd, 32'hDEAD_BEEF);
        chk("ld_deadbeef_err", 32'(e), 32'd0);

        do_access(0, 1'b1, 32'h14, 32'hAABB_CCDD, 4'hF, rd, e);
        do_access(0, 1'b1, 32'h14, 32'h1122_3344, 4'h5, rd, e);
        do_access(0, 1'b1, 32'h14, 32'h5555_5555, 4'h0, rd, e);
        chk("be0_no_err", 32'(e), 32'd0);
        do_access(0, 1'b0, 32'h14, 32'h0, 4'h0, rd, e);
        chk("partial", rd, 32'hAA22_CC44);

        do_access(0, 1'b1, 32'h0, 32'h0123_4567, 4'hF, rd, e);
        do_access(0, 1'b0, 32'h1000, 32'h0, 4'hF, rd, e);
        chk("oor_ld_err", 32'(e), 32'd1);
        chk("oor_ld_rdata", rd, 32'd0);
        do_access(0, 1'b1, 32'h1000, 32'hBAD0_BAD0, 4'hF, rd, e);
        chk("oor_st_err", 32'(e), 32'd1);
        do_access(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, e);
        chk("oor_no_wrap", rd, 32'h0123_4567);

        do_access(0, 1'b1, 32'h12, 32'hCAFE_F00D, 4'hF, rd, e);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_err", 32'(e), 32'd1);
        exp36 = 32'hDEAD_BEEF;
`else
        chk("mis_err", 32'(e), 32'd0);
        exp36 = 32'hCAFE_F00D;
`endif
        do_access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e);
        chk("mis_word4", rd, exp36);

        // Store aborted by reset while waiting.
        @(negedge clk);
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 32'hC;
        wdata[0] = 32'h5A5A_5A5A;
        be[0]    = 4'hF;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt[0]), 32'd0);
        chk("abort_rvalid", 32'(rvalid[0]), 32'd0);
        chk("abort_err", 32'(err[0]), 32'd0);
        repeat (2) @(negedge clk);
        req[0] = 1'b0;
        rst    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rvalid", 32'(rvalid[0]), 32'd0);
        end
        do_access(0, 1'b0, 32'hC, 32'h0, 4'h0, rd, e);

        // Zero-wait instance with request held for three loads.
        @(negedge clk);
        req[1]  = 1'b1;
        we[1]   = 1'b0;
        addr[1] = 32'h8;
        be[1]   = 4'h0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("held_gnt", 32'(gnt[1]), 32'(i % 2 == 0));
            chk("held_rvalid", 32'(rvalid[1]), 32'(i % 2 == 1));
            if (i % 2 == 1) chk("held_rdata", rdata[1], mem_m[1][2]);
            if (i == 5) req[1] = 1'b0;
            @(negedge clk);
        end

        for (int k = 0; k < 240; k++) begin
            int          d;
            int          r;
            logic [31:0] a;
            d = k % 2;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                a = 32'h1000 | $urandom;
            end else if (r < 3) begin
                a = 32'($urandom_range(0, 63));
            end else begin
                a = 32'($urandom_range(0, 15)) << 2;
            end
            do_access(d, 1'($urandom), a, $urandom,
                      4'($urandom), rd, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
